// File: rtl/eth_data_pkg.sv
// Shared definitions for the Ethernet data receive path: FSM states, framing
// constants and the expected-payload-length helper.
package eth_data_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IDX_LO  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_UNIT = 8;
  localparam int unsigned LEN_WIDTH      = 11;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  function automatic logic [LEN_WIDTH-1:0] exp_len(input logic [7:0] packagesize);
    return LEN_WIDTH'(packagesize) * LEN_WIDTH'(BYTES_PER_UNIT);
  endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating statistics counter with a variable increment and a clear that
// overrides any same-cycle increment.
module eth_sat_counter #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int unsigned SUM_WIDTH = ((CNT_WIDTH > INC_WIDTH) ? CNT_WIDTH : INC_WIDTH) + 1;

  logic [SUM_WIDTH-1:0] sum;

  always_comb sum = SUM_WIDTH'(count) + SUM_WIDTH'(inc);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (sum[SUM_WIDTH-1:CNT_WIDTH] != '0)
      count <= '1;
    else
      count <= sum[CNT_WIDTH-1:0];
  end

endmodule

// File: rtl/ethernet_data_receiver.sv
// Strips the 2-byte package index from framed UDP packages, forwards payload
// to a FIFO and keeps sequence, length and timeout statistics.
module ethernet_data_receiver
  import eth_data_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           packagesize,
  input  logic [23:0]          timeout,
  input  logic                 clear_counters,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_lastbyte,
  output logic                 rx_ready,
  output logic [7:0]           dataout,
  output logic                 dataout_wr_en,
  input  logic                 dataout_full,
  output logic [15:0]          last_index,
  output logic                 package_done,
  output logic [CNT_WIDTH-1:0] package_count,
  output logic [CNT_WIDTH-1:0] lost_packages,
  output logic [CNT_WIDTH-1:0] length_errors,
  output logic [CNT_WIDTH-1:0] timeout_errors
);

  state_t               state;
  logic                 sync;
  logic [15:0]          expected;
  logic [7:0]           idx_hi;
  logic [LEN_WIDTH-1:0] exp_len_r;
  logic [LEN_WIDTH-1:0] bytecnt;
  logic [23:0]          tcnt;

  logic                 accept;
  logic [15:0]          idx;
  logic [15:0]          gap;
  logic                 pkg_end;
  logic [LEN_WIDTH:0]   pkg_len;
  logic                 len_err;
  logic                 tmo_hit;

  always_comb begin
    rx_ready = enable & ~dataout_full & ~reset;
    accept   = rx_valid & rx_ready;
    idx      = {idx_hi, rx_data};
    gap      = '0;
    pkg_end  = 1'b0;
    pkg_len  = '0;
    len_err  = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      IDLE:    len_err = accept & rx_lastbyte;
      IDX_LO: begin
        if (accept && sync && (idx != expected))
          gap = idx - expected;
        pkg_end = accept & rx_lastbyte;
      end
      PAYLOAD: begin
        pkg_end = accept & rx_lastbyte;
        pkg_len = {1'b0, bytecnt} + 1'b1;
      end
      default: ;
    endcase
    if (pkg_end && (pkg_len != {1'b0, exp_len_r}))
      len_err = 1'b1;
    // Idle cycles only count while the FIFO is able to take data.
    if ((state != IDLE) && enable && !accept && !dataout_full &&
        (timeout != '0) && (tcnt == timeout - 24'd1))
      tmo_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sync          <= 1'b0;
      expected      <= '0;
      idx_hi        <= '0;
      exp_len_r     <= '0;
      bytecnt       <= '0;
      tcnt          <= '0;
      dataout       <= '0;
      dataout_wr_en <= 1'b0;
      package_done  <= 1'b0;
      last_index    <= '0;
    end else begin
      dataout_wr_en <= 1'b0;
      package_done  <= pkg_end;
      if (!enable) begin
        state <= IDLE;
        sync  <= 1'b0;
        tcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            tcnt <= '0;
            if (accept && !rx_lastbyte) begin
              idx_hi    <= rx_data;
              exp_len_r <= exp_len(packagesize);
              state     <= IDX_LO;
            end
          end
          IDX_LO: begin
            if (accept) begin
              last_index <= idx;
              expected   <= idx + 16'd1;
              sync       <= 1'b1;
              bytecnt    <= '0;
              tcnt       <= '0;
              state      <= rx_lastbyte ? IDLE : PAYLOAD;
            end else if (tmo_hit) begin
              tcnt  <= '0;
              state <= IDLE;
            end else if (!dataout_full) begin
              tcnt <= tcnt + 24'd1;
            end
          end
          PAYLOAD: begin
            if (accept) begin
              dataout       <= rx_data;
              dataout_wr_en <= 1'b1;
              tcnt          <= '0;
              if (bytecnt != LEN_MAX)
                bytecnt <= bytecnt + 1'b1;
              if (rx_lastbyte)
                state <= IDLE;
            end else if (tmo_hit) begin
              tcnt  <= '0;
              state <= IDLE;
            end else if (!dataout_full) begin
              tcnt <= tcnt + 24'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  eth_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_package_count (
    .clk(clk), .reset(reset), .clear(clear_counters), .inc(pkg_end), .count(package_count)
  );

  eth_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(16)) u_lost_packages (
    .clk(clk), .reset(reset), .clear(clear_counters), .inc(gap), .count(lost_packages)
  );

  eth_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_length_errors (
    .clk(clk), .reset(reset), .clear(clear_counters), .inc(len_err), .count(length_errors)
  );

  eth_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_timeout_errors (
    .clk(clk), .reset(reset), .clear(clear_counters), .inc(tmo_hit), .count(timeout_errors)
  );

endmodule

// File: tb/tb_ethernet_data_receiver.sv
// Bench for ethernet_data_receiver: package table, multi-cycle corner cases
// and randomized packages against a package-level reference model.
module tb_ethernet_data_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  packagesize = '0;
  logic [23:0] timeout = '0;
  logic        clear_counters = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_lastbyte = 1'b0;
  logic        rx_ready;
  logic [7:0]  dataout;
  logic        dataout_wr_en;
  logic        dataout_full = 1'b0;
  logic [15:0] last_index;
  logic        package_done;
  logic [15:0] package_count, lost_packages, length_errors, timeout_errors;

  ethernet_data_receiver #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .packagesize(packagesize),
    .timeout(timeout), .clear_counters(clear_counters), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_lastbyte(rx_lastbyte), .rx_ready(rx_ready),
    .dataout(dataout), .dataout_wr_en(dataout_wr_en), .dataout_full(dataout_full),
    .last_index(last_index), .package_done(package_done),
    .package_count(package_count), .lost_packages(lost_packages),
    .length_errors(length_errors), .timeout_errors(timeout_errors)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state, kept at package granularity.
  int          m_count = 0, m_lost = 0, m_lenerr = 0, m_tmo = 0, m_done = 0;
  bit          m_sync = 0;
  logic [15:0] m_exp = '0, m_last = '0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          done_seen = 0;
  bit          full_rand = 0;

  typedef struct {
    logic [15:0] idx;
    int          nb;
    logic [7:0]  ps;
    int          lost;
    int          lenerr;
    int          count;
  } vec_t;
  vec_t tbl[9];

  initial forever begin
    @(negedge clk);
    if (dataout_wr_en === 1'b1) got_q.push_back(dataout);
    if (package_done === 1'b1) done_seen++;
  end

  initial forever begin
    @(negedge clk);
    if (full_rand) dataout_full = ($urandom_range(0, 3) == 0);
  end

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic put_byte(input logic [7:0] d, input bit last, input int gapmax);
    bit got;
    got = 0;
    if (gapmax > 0) repeat ($urandom_range(0, gapmax)) @(negedge clk);
    rx_data = d; rx_valid = 1'b1; rx_lastbyte = last;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      got = (rx_ready === 1'b1);
      @(negedge clk);
    end
    rx_valid = 1'b0; rx_lastbyte = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept_wait actual=not_accepted required=accepted");
    end
  endtask

  task automatic hdr(input logic [15:0] idx, input logic [7:0] ps, input bit last, input int g);
    logic [7:0]  b;
    logic [15:0] diff;
    packagesize = ps;
    b = idx[15:8]; put_byte(b, 1'b0, g);
    b = idx[7:0];  put_byte(b, last, g);
    diff = idx - m_exp;
    if (m_sync && idx != m_exp) m_lost = sat16(m_lost + int'(diff));
    m_exp = idx + 16'd1; m_sync = 1; m_last = idx;
  endtask

  task automatic body(input int n, input bit last, input int g);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      put_byte(d, last && (k == n - 1), g);
    end
  endtask

  task automatic end_model(input int len, input logic [7:0] ps);
    m_count = sat16(m_count + 1);
    m_done++;
    if (len != int'(ps) * 8) m_lenerr = sat16(m_lenerr + 1);
  endtask

  task automatic send_pkg(input logic [15:0] idx, input int nb, input logic [7:0] ps, input int g);
    hdr(idx, ps, nb == 0, g);
    body(nb, 1'b1, g);
    end_model(nb, ps);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, ".package_count"}, package_count, m_count);
    chk({tag, ".lost_packages"}, lost_packages, m_lost);
    chk({tag, ".length_errors"}, length_errors, m_lenerr);
    chk({tag, ".timeout_errors"}, timeout_errors, m_tmo);
    chk({tag, ".last_index"}, last_index, m_last);
    chk({tag, ".package_done"}, done_seen, m_done);
  endtask

  task automatic verify(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, ".writes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, ".byte"}, got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
    check_stats(tag);
  endtask

  task automatic zero_counts();
    m_count = 0; m_lost = 0; m_lenerr = 0; m_tmo = 0;
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] idx;
    logic [7:0]  ps;
    int          n, nb, r;

    tbl = '{
      '{16'd1,     16, 8'd2, 0,     0, 1},
      '{16'd2,     16, 8'd2, 0,     0, 2},
      '{16'd5,     16, 8'd2, 2,     0, 3},
      '{16'hFFFF,   8, 8'd1, 65531, 0, 4},
      '{16'h0000,  16, 8'd2, 65531, 0, 5},
      '{16'd1,     10, 8'd2, 65531, 1, 6},
      '{16'd2,      0, 8'd0, 65531, 1, 7},
      '{16'd3,      0, 8'd1, 65531, 2, 8},
      '{16'd100,   16, 8'd2, 65535, 2, 9}
    };

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.rx_ready", rx_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset.dataout", dataout, 0);
    chk("reset.dataout_wr_en", dataout_wr_en, 0);
    check_stats("reset");

    // Table of packages with hand-derived cumulative statistics
    foreach (tbl[i]) begin
      send_pkg(tbl[i].idx, tbl[i].nb, tbl[i].ps, 1);
      repeat (3) @(negedge clk);
      chk("tbl.package_count", package_count, tbl[i].count);
      chk("tbl.lost_packages", lost_packages, tbl[i].lost);
      chk("tbl.length_errors", length_errors, tbl[i].lenerr);
      chk("tbl.last_index", last_index, tbl[i].idx);
      verify("tbl");
    end

    // Stand-alone clear
    clear_counters = 1'b1; @(negedge clk); clear_counters = 1'b0;
    zero_counts();
    verify("clear");

    // Runt: lastbyte on the first header byte
    put_byte(8'hAA, 1'b1, 0);
    m_lenerr++;
    verify("runt");

    // Inter-byte timeout after 4 payload bytes
    timeout = 24'd100;
    hdr(m_exp, 8'd2, 1'b0, 0);
    body(4, 1'b0, 0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (timeout_errors != 16'(m_tmo)) break;
    end
    chk("timeout.cycle", n, 100);
    m_tmo++;
    verify("timeout");
    send_pkg(m_exp, 16, 8'd2, 0);
    verify("after_timeout");

    // FIFO full stall longer than the timeout
    timeout = 24'd10;
    hdr(m_exp, 8'd2, 1'b0, 0);
    body(5, 1'b0, 0);
    dataout_full = 1'b1;
    d = 8'($urandom_range(0, 255));
    rx_data = d; rx_valid = 1'b1;
    repeat (50) @(negedge clk);
    chk("full.rx_ready", rx_ready, 0);
    dataout_full = 1'b0;
    exp_q.push_back(d);
    put_byte(d, 1'b0, 0);
    body(10, 1'b1, 0);
    end_model(16, 8'd2);
    verify("full_stall");

    // Clear in the same cycle as a package end
    hdr(m_exp, 8'd1, 1'b0, 0);
    body(7, 1'b0, 0);
    d = 8'h5C;
    exp_q.push_back(d);
    clear_counters = 1'b1;
    put_byte(d, 1'b1, 0);
    clear_counters = 1'b0;
    zero_counts();
    m_done++;
    verify("clear_priority");

    // Reset mid-payload
    send_pkg(16'd7, 8, 8'd1, 0);
    hdr(16'd20, 8'd2, 1'b0, 0);
    body(3, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset.rx_ready", rx_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    zero_counts(); m_sync = 0; m_last = '0;
    verify("midreset");
    send_pkg(16'h1234, 16, 8'd2, 0);
    verify("after_reset");

    // Enable drop mid-payload
    hdr(m_exp, 8'd2, 1'b0, 0);
    body(2, 1'b0, 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("disable.rx_ready", rx_ready, 0);
    enable = 1'b1;
    m_sync = 0;
    send_pkg(16'h0100, 16, 8'd2, 0);
    verify("after_disable");

    // Randomized packages with FIFO back-pressure
    timeout = 24'd500;
    full_rand = 1;
    for (int p = 0; p < 40; p++) begin
      ps = 8'($urandom_range(0, 4));
      nb = int'(ps) * 8;
      if ($urandom_range(0, 4) == 0) nb = $urandom_range(0, 40);
      r = $urandom_range(0, 5);
      if (r == 0)      idx = m_exp + 16'($urandom_range(1, 3));
      else if (r == 1) idx = 16'($urandom);
      else             idx = m_exp;
      send_pkg(idx, nb, ps, 2);
      verify("random");
    end
    full_rand = 0;
    @(negedge clk);
    dataout_full = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
